// File: rtl/alu_seq_pkg.sv
// Shared types and helpers for the nibble-serial 74181 sequencer.
package alu_seq_pkg;

  // Sequencer control states.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  // Width of one 74181 slice.
  localparam int unsigned NIB_W = 4;

  // Upper bound on operand width accepted by nibble_of.
  localparam int unsigned VEC_MAX_W = 1024;

  // Extract nibble idx (0 = least significant) from a zero-extended vector.
  function automatic logic [NIB_W-1:0] nibble_of(input logic [VEC_MAX_W-1:0] vec,
                                                 input int unsigned          idx);
    return vec[idx*NIB_W +: NIB_W];
  endfunction

endpackage

// File: rtl/alu_nibble_sequencer.sv
// Nibble-serial initiator for one external 74181 slice: feeds A/B/S/M/Cn
// one nibble at a time (LSB first), chains Cn+4 back into Cn through time,
// and assembles a WIDTH-bit result, carry-out and A=B flag.
module alu_nibble_sequencer
  import alu_seq_pkg::*;
#(
  parameter int unsigned WIDTH  = 16,
  parameter int unsigned SETTLE = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  input  logic [3:0]       sel,
  input  logic             mode,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             cout,
  output logic             aeqb,
  output logic [3:0]       alu_a,
  output logic [3:0]       alu_b,
  output logic [3:0]       alu_s,
  output logic             alu_m,
  output logic             alu_cn,
  input  logic [3:0]       alu_f,
  input  logic             alu_cn4,
  input  logic             alu_aeqb
);

  localparam int unsigned NIB   = WIDTH / NIB_W;
  localparam int unsigned IDX_W = (NIB > 1) ? $clog2(NIB) : 1;
  localparam int unsigned CNT_W = (SETTLE > 1) ? $clog2(SETTLE) : 1;

  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NIB - 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SETTLE - 1);

  state_e             state_q,  state_d;
  logic [IDX_W-1:0]   idx_q,    idx_d;
  logic [CNT_W-1:0]   cnt_q,    cnt_d;
  logic [WIDTH-1:0]   opa_q,    opa_d;
  logic [WIDTH-1:0]   opb_q,    opb_d;
  logic [WIDTH-1:0]   result_q, result_d;
  logic               cout_q,   cout_d;
  logic               aeqb_q,   aeqb_d;
  logic [3:0]         alu_a_q,  alu_a_d;
  logic [3:0]         alu_b_q,  alu_b_d;
  logic [3:0]         alu_s_q,  alu_s_d;
  logic               alu_m_q,  alu_m_d;
  logic               alu_cn_q, alu_cn_d;

  // State and datapath registers; reset clears everything, discarding any
  // in-flight sample.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      idx_q    <= '0;
      cnt_q    <= '0;
      opa_q    <= '0;
      opb_q    <= '0;
      result_q <= '0;
      cout_q   <= 1'b0;
      aeqb_q   <= 1'b0;
      alu_a_q  <= '0;
      alu_b_q  <= '0;
      alu_s_q  <= '0;
      alu_m_q  <= 1'b0;
      alu_cn_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      cnt_q    <= cnt_d;
      opa_q    <= opa_d;
      opb_q    <= opb_d;
      result_q <= result_d;
      cout_q   <= cout_d;
      aeqb_q   <= aeqb_d;
      alu_a_q  <= alu_a_d;
      alu_b_q  <= alu_b_d;
      alu_s_q  <= alu_s_d;
      alu_m_q  <= alu_m_d;
      alu_cn_q <= alu_cn_d;
    end
  end

  // Next-state logic: accept in IDLE, settle/sample/advance in RUN,
  // single-cycle DONE.
  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    cnt_d    = cnt_q;
    opa_d    = opa_q;
    opb_d    = opb_q;
    result_d = result_q;
    cout_d   = cout_q;
    aeqb_d   = aeqb_q;
    alu_a_d  = alu_a_q;
    alu_b_d  = alu_b_q;
    alu_s_d  = alu_s_q;
    alu_m_d  = alu_m_q;
    alu_cn_d = alu_cn_q;

    unique case (state_q)
      IDLE: begin
        if (start) begin
          opa_d    = op_a;
          opb_d    = op_b;
          alu_a_d  = nibble_of(VEC_MAX_W'(op_a), 0);
          alu_b_d  = nibble_of(VEC_MAX_W'(op_b), 0);
          alu_s_d  = sel;
          alu_m_d  = mode;
          alu_cn_d = cin;
          aeqb_d   = 1'b1;
          result_d = '0;
          cout_d   = 1'b0;
          idx_d    = '0;
          cnt_d    = '0;
          state_d  = RUN;
        end
      end

      RUN: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_LAST) begin
          result_d[NIB_W*idx_q +: NIB_W] = alu_f;
          aeqb_d = aeqb_q & alu_aeqb;
          if (idx_q != IDX_LAST) begin
            // Carry is forwarded in raw 74181 polarity into the next nibble.
            idx_d    = idx_q + IDX_W'(1);
            cnt_d    = '0;
            alu_a_d  = nibble_of(VEC_MAX_W'(opa_q), 32'(idx_d));
            alu_b_d  = nibble_of(VEC_MAX_W'(opb_q), 32'(idx_d));
            alu_cn_d = alu_cn4;
          end else begin
            cout_d  = alu_cn4;
            state_d = DONE;
          end
        end
      end

      DONE: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Status decodes straight from the state register.
  always_comb begin
    busy = (state_q == RUN);
    done = (state_q == DONE);
  end

  assign result = result_q;
  assign cout   = cout_q;
  assign aeqb   = aeqb_q;
  assign alu_a  = alu_a_q;
  assign alu_b  = alu_b_q;
  assign alu_s  = alu_s_q;
  assign alu_m  = alu_m_q;
  assign alu_cn = alu_cn_q;

endmodule

// File: tb/tb_alu_nibble_sequencer.sv
// Bench for alu_nibble_sequencer: two instances (SETTLE=1 and SETTLE=3),
// each wired to a behavioural 74181 slice.
module tb_alu_nibble_sequencer;

  logic clk;
  logic rst;
  logic cn_flip;

  int n_checks = 0;
  int n_errors = 0;

  // SETTLE=1 instance signals
  logic        s1_start, s1_mode, s1_cin, s1_busy, s1_done, s1_cout, s1_aeqb;
  logic [15:0] s1_op_a, s1_op_b, s1_result;
  logic [3:0]  s1_sel, s1_alu_a, s1_alu_b, s1_alu_s, s1_alu_f;
  logic        s1_alu_m, s1_alu_cn, s1_alu_cn4, s1_alu_aeqb;

  // SETTLE=3 instance signals
  logic        s3_start, s3_mode, s3_cin, s3_busy, s3_done, s3_cout, s3_aeqb;
  logic [15:0] s3_op_a, s3_op_b, s3_result;
  logic [3:0]  s3_sel, s3_alu_a, s3_alu_b, s3_alu_s, s3_alu_f;
  logic        s3_alu_m, s3_alu_cn, s3_alu_cn4, s3_alu_aeqb;

  typedef struct {
    logic [15:0] a, b;
    logic [3:0]  sel;
    logic        mode, cin, flip;
    logic [15:0] res;
    logic        cout, aeqb;
    logic        chk_chain;
    logic [3:0]  chain;
  } vec_t;

  typedef struct {
    logic [15:0] res;
    logic        cout, aeqb;
  } exp_t;

  vec_t vecs[$];
  exp_t sb_q[$];

  // 74181, active-high data: returns {F, Cn+4, A=B}.
  function automatic logic [5:0] alu181(input logic [3:0] a, b, s,
                                        input logic m, cn);
    logic [3:0] u, v, f;
    logic [4:0] sum;
    u   = a | (b & {4{s[0]}}) | (~b & {4{s[1]}});
    v   = (a & ~b & {4{s[2]}}) | (a & b & {4{s[3]}});
    sum = {1'b0, u} + {1'b0, v} + {4'b0000, ~cn};
    f   = m ? ~(u ^ v) : sum[3:0];
    return {f, ~sum[4], &f};
  endfunction

  alu_nibble_sequencer #(.WIDTH(16), .SETTLE(1)) u_dut1 (
    .clk(clk), .rst(rst), .start(s1_start), .op_a(s1_op_a), .op_b(s1_op_b),
    .sel(s1_sel), .mode(s1_mode), .cin(s1_cin), .busy(s1_busy), .done(s1_done),
    .result(s1_result), .cout(s1_cout), .aeqb(s1_aeqb), .alu_a(s1_alu_a),
    .alu_b(s1_alu_b), .alu_s(s1_alu_s), .alu_m(s1_alu_m), .alu_cn(s1_alu_cn),
    .alu_f(s1_alu_f), .alu_cn4(s1_alu_cn4), .alu_aeqb(s1_alu_aeqb)
  );

  alu_nibble_sequencer #(.WIDTH(16), .SETTLE(3)) u_dut3 (
    .clk(clk), .rst(rst), .start(s3_start), .op_a(s3_op_a), .op_b(s3_op_b),
    .sel(s3_sel), .mode(s3_mode), .cin(s3_cin), .busy(s3_busy), .done(s3_done),
    .result(s3_result), .cout(s3_cout), .aeqb(s3_aeqb), .alu_a(s3_alu_a),
    .alu_b(s3_alu_b), .alu_s(s3_alu_s), .alu_m(s3_alu_m), .alu_cn(s3_alu_cn),
    .alu_f(s3_alu_f), .alu_cn4(s3_alu_cn4), .alu_aeqb(s3_alu_aeqb)
  );

  // Slice models; cn_flip inverts the carry seen by the first slice.
  always_comb {s1_alu_f, s1_alu_cn4, s1_alu_aeqb} =
      alu181(s1_alu_a, s1_alu_b, s1_alu_s, s1_alu_m, s1_alu_cn ^ cn_flip);
  always_comb {s3_alu_f, s3_alu_cn4, s3_alu_aeqb} =
      alu181(s3_alu_a, s3_alu_b, s3_alu_s, s3_alu_m, s3_alu_cn);

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, want %0h", name, act, exp);
    end
  endtask

  // One operation on the SETTLE=1 instance with scoreboard and timing checks.
  task automatic run_vec(input vec_t v);
    exp_t        e;
    int          lat;
    bit          seen;
    int          busy_bad;
    logic [3:0]  chain;
    @(negedge clk);
    s1_op_a = v.a; s1_op_b = v.b; s1_sel = v.sel; s1_mode = v.mode;
    s1_cin = v.cin; cn_flip = v.flip; s1_start = 1'b1;
    sb_q.push_back('{v.res, v.cout, v.aeqb});
    @(negedge clk);
    s1_start = 1'b0;
    seen = 0; lat = 0; busy_bad = 0; chain = '0;
    for (int k = 0; k < 20; k++) begin
      if (s1_done) begin
        seen = 1; lat = k;
        break;
      end
      if (s1_busy !== 1'b1) busy_bad++;
      if (k < 4) chain[k] = s1_alu_cn;
      @(negedge clk);
    end
    check("latency", seen ? 64'(lat) : 64'd999, 64'd4);
    check("busy_during_run", 64'(busy_bad), 64'd0);
    e = sb_q.pop_front();
    if (seen) begin
      check("busy_low_at_done", 64'(s1_busy), 64'd0);
      check("result", 64'(s1_result), 64'(e.res));
      check("cout", 64'(s1_cout), 64'(e.cout));
      check("aeqb", 64'(s1_aeqb), 64'(e.aeqb));
      check("alu_s_m_held", {s1_alu_s, s1_alu_m}, {v.sel, v.mode});
    end
    if (v.chk_chain) check("cn_chain", 64'(chain), 64'(v.chain));
    @(negedge clk);
    check("done_pulse", 64'(s1_done), 64'd0);
    check("result_hold", 64'(s1_result), 64'(e.res));
    cn_flip = 1'b0;
  endtask

  initial begin
    vec_t        rv;
    logic [16:0] sum17;
    logic [15:0] ea;
    int          hold_bad;
    int          lat;
    bit          seen;

    rst = 1'b1; cn_flip = 1'b0;
    s1_start = 0; s1_op_a = '0; s1_op_b = '0; s1_sel = '0; s1_mode = 0; s1_cin = 0;
    s3_start = 0; s3_op_a = '0; s3_op_b = '0; s3_sel = '0; s3_mode = 0; s3_cin = 0;
    repeat (3) @(negedge clk);
    check("reset_dut1", {s1_busy, s1_done, s1_result, s1_cout, s1_aeqb, s1_alu_a,
                         s1_alu_b, s1_alu_s, s1_alu_m, s1_alu_cn}, 64'd0);
    check("reset_dut3", {s3_busy, s3_done, s3_result, s3_cout, s3_aeqb, s3_alu_a,
                         s3_alu_b, s3_alu_s, s3_alu_m, s3_alu_cn}, 64'd0);
    rst = 1'b0;

    // a, b, sel, mode, cin, flip, result, cout, aeqb, chk_chain, chain
    vecs.push_back('{16'h1234, 16'h1111, 4'b1001, 1'b0, 1'b1, 1'b0, 16'h2345, 1'b1, 1'b0, 1'b1, 4'b1111});
    vecs.push_back('{16'hFFFF, 16'h0001, 4'b1001, 1'b0, 1'b1, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b1, 4'b0001});
    vecs.push_back('{16'hA5A5, 16'hFFFF, 4'b0110, 1'b1, 1'b1, 1'b0, 16'h5A5A, 1'b1, 1'b0, 1'b1, 4'b1111});
    vecs.push_back('{16'hA5A5, 16'hFFFF, 4'b0110, 1'b1, 1'b0, 1'b0, 16'h5A5A, 1'b1, 1'b0, 1'b1, 4'b1110});
    vecs.push_back('{16'hA5A5, 16'hFFFF, 4'b0110, 1'b1, 1'b1, 1'b1, 16'h5A5A, 1'b1, 1'b0, 1'b1, 4'b1111});
    vecs.push_back('{16'h3C3C, 16'h3C3C, 4'b0110, 1'b0, 1'b1, 1'b0, 16'hFFFF, 1'b1, 1'b1, 1'b1, 4'b1111});
    vecs.push_back('{16'h3C3C, 16'h3C3D, 4'b0110, 1'b0, 1'b1, 1'b0, 16'hFFFE, 1'b1, 1'b0, 1'b1, 4'b1111});
    vecs.push_back('{16'h0005, 16'h0003, 4'b0110, 1'b0, 1'b0, 1'b0, 16'h0002, 1'b0, 1'b0, 1'b1, 4'b0000});
    vecs.push_back('{16'hF0F0, 16'hFF00, 4'b1011, 1'b1, 1'b1, 1'b0, 16'hF000, 1'b0, 1'b0, 1'b1, 4'b1111});
    vecs.push_back('{16'hFFFF, 16'hFFFF, 4'b1011, 1'b1, 1'b1, 1'b0, 16'hFFFF, 1'b0, 1'b1, 1'b1, 4'b0001});
    for (int i = 0; i < 4; i++) begin
      rv.a = 16'($urandom_range(0, 65535));
      rv.b = 16'($urandom_range(0, 65535));
      rv.cin = 1'($urandom_range(0, 1));
      rv.sel = 4'b1001; rv.mode = 1'b0; rv.flip = 1'b0;
      sum17 = {1'b0, rv.a} + {1'b0, rv.b} + {16'd0, ~rv.cin};
      rv.res = sum17[15:0];
      rv.cout = ~sum17[16];
      rv.aeqb = &sum17[15:0];
      rv.chk_chain = 1'b0; rv.chain = '0;
      vecs.push_back(rv);
    end
    foreach (vecs[i]) run_vec(vecs[i]);

    // Reset in the middle of an add, then a clean operation.
    @(negedge clk);
    s1_op_a = 16'h1234; s1_op_b = 16'h1111; s1_sel = 4'b1001; s1_mode = 1'b0;
    s1_cin = 1'b1; s1_start = 1'b1;
    @(negedge clk);
    s1_start = 1'b0;
    @(negedge clk);
    check("partial_nibble0", 64'(s1_result), 64'h0005);
    rst = 1'b1;
    @(negedge clk);
    check("midop_reset", {s1_busy, s1_done, s1_result, s1_cout, s1_aeqb, s1_alu_a,
                          s1_alu_b, s1_alu_s, s1_alu_m, s1_alu_cn}, 64'd0);
    rst = 1'b0;
    run_vec('{16'h0001, 16'h0002, 4'b1001, 1'b0, 1'b1, 1'b0, 16'h0003, 1'b1, 1'b0, 1'b1, 4'b1111});

    // SETTLE=3: hold time, latency, ignored starts, restart right after DONE.
    ea = 16'h1234; hold_bad = 0; seen = 0; lat = 0;
    @(negedge clk);
    s3_op_a = ea; s3_op_b = 16'h1111; s3_sel = 4'b1001; s3_mode = 1'b0;
    s3_cin = 1'b1; s3_start = 1'b1;
    @(negedge clk);
    s3_start = 1'b0;
    for (int k = 0; k < 40; k++) begin
      if (s3_done) begin
        seen = 1; lat = k;
        break;
      end
      if (k < 12 && s3_alu_a !== ea[4*(k/3) +: 4]) hold_bad++;
      s3_start = (k == 1);
      s3_op_a  = (k == 1) ? 16'hFFFF : ea;
      @(negedge clk);
    end
    check("s3_latency", seen ? 64'(lat) : 64'd999, 64'd12);
    check("s3_alu_a_hold", 64'(hold_bad), 64'd0);
    check("s3_result", 64'(s3_result), 64'h2345);
    check("s3_cout", 64'(s3_cout), 64'd1);
    s3_op_a = 16'hFFFF; s3_op_b = 16'h0001; s3_start = 1'b1;
    @(negedge clk);
    check("s3_start_in_done_ignored", {s3_busy, s3_done}, 64'd0);
    check("s3_result_hold", 64'(s3_result), 64'h2345);
    s3_op_a = 16'h00FF; s3_op_b = 16'h0001;
    @(negedge clk);
    s3_start = 1'b0;
    check("s3_accept_after_done", 64'(s3_busy), 64'd1);
    seen = 0; lat = 0;
    for (int k = 0; k < 40; k++) begin
      if (s3_done) begin
        seen = 1; lat = k;
        break;
      end
      @(negedge clk);
    end
    check("s3_latency2", seen ? 64'(lat) : 64'd999, 64'd12);
    check("s3_result2", {s3_result, s3_cout, s3_aeqb}, {16'h0100, 1'b1, 1'b0});

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
